// File: rtl/pause_frame_scheduler_if.sv
// Pause request bundle between the RX FIFO level / config and the MAC transmit pause inputs.
// The scheduler is the master of the request; the MAC side is the slave.
interface pause_frame_scheduler_if #(
  parameter int FILL_W = 12
);
  logic [FILL_W-1:0] fifo_level;
  logic              pause_enable;
  logic              tx_pause_ack;
  logic              tx_pause_req;
  logic [15:0]       tx_pause_val;
  logic [47:0]       tx_pause_source_addr_r;
  logic              paused;
  logic [15:0]       xoff_count;

  modport master (
    input  fifo_level,
    input  pause_enable,
    input  tx_pause_ack,
    output tx_pause_req,
    output tx_pause_val,
    output tx_pause_source_addr_r,
    output paused,
    output xoff_count
  );

  modport slave (
    output fifo_level,
    output pause_enable,
    output tx_pause_ack,
    input  tx_pause_req,
    input  tx_pause_val,
    input  tx_pause_source_addr_r,
    input  paused,
    input  xoff_count
  );
endinterface

// File: rtl/pause_frame_scheduler.sv
// XOFF/XON pause request scheduler: FIFO-level hysteresis, periodic XOFF refresh while
// congested, each request held until the MAC acknowledges it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | link partner not paused, watching for level >= XOFF_THRESH
// XOFF_REQ  | XOFF (pause_time = PAUSE_QUANTA) requested, waiting for ack
// PAUSED    | XOFF accepted, refresh timer running, watching for XON cause
// XON_REQ   | XON (pause_time = 0) requested, waiting for ack
module pause_frame_scheduler #(
  parameter int          FILL_W         = 12,
  parameter int          XOFF_THRESH    = 3072,
  parameter int          XON_THRESH     = 1024,
  parameter logic [15:0] PAUSE_QUANTA   = 16'h5A0F,
  parameter int          REFRESH_W      = 20,
  parameter int          REFRESH_CYCLES = 500000,
  parameter logic [47:0] PAUSE_DA       = 48'h0180C2000001
) (
  input  logic tx_clk,
  input  logic rst,
  pause_frame_scheduler_if.master pif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_XOFF_REQ = 2'd1;
  localparam logic [1:0] ST_PAUSED   = 2'd2;
  localparam logic [1:0] ST_XON_REQ  = 2'd3;

  localparam logic [FILL_W-1:0]    XOFF_LVL = XOFF_THRESH[FILL_W-1:0];
  localparam logic [FILL_W-1:0]    XON_LVL  = XON_THRESH[FILL_W-1:0];
  localparam logic [REFRESH_W-1:0] RELOAD   = REFRESH_W'(REFRESH_CYCLES - 1);
  localparam logic [15:0]          CNT_MAX  = 16'hFFFF;

  logic [1:0]           state_q, state_d;
  logic                 req_q, req_d;
  logic [15:0]          val_q, val_d;
  logic [47:0]          addr_q, addr_d;
  logic                 paused_q, paused_d;
  logic [15:0]          xoff_cnt_q, xoff_cnt_d;
  logic [REFRESH_W-1:0] refresh_q, refresh_d;

  logic ack_valid;
  logic xoff_cause;
  logic xon_cause;
  logic refresh_tc;

  // An ack only counts once our request has been visible for at least a cycle.
  assign ack_valid  = pif.tx_pause_ack && req_q;
  assign xoff_cause = pif.pause_enable && (pif.fifo_level >= XOFF_LVL);
  assign xon_cause  = !pif.pause_enable || (pif.fifo_level <= XON_LVL);
  assign refresh_tc = (refresh_q == '0);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    val_d      = val_q;
    addr_d     = addr_q;
    paused_d   = paused_q;
    xoff_cnt_d = xoff_cnt_q;
    refresh_d  = refresh_q;

    case (state_q)
      ST_IDLE: begin
        if (xoff_cause) begin
          state_d = ST_XOFF_REQ;
          req_d   = 1'b1;
          val_d   = PAUSE_QUANTA;
          addr_d  = PAUSE_DA;
        end
      end

      ST_XOFF_REQ: begin
        if (ack_valid) begin
          state_d   = ST_PAUSED;
          req_d     = 1'b0;
          val_d     = '0;
          addr_d    = '0;
          paused_d  = 1'b1;
          refresh_d = RELOAD;
          if (xoff_cnt_q != CNT_MAX) begin
            xoff_cnt_d = xoff_cnt_q + 16'd1;
          end
        end
      end

      ST_PAUSED: begin
        // XON takes priority over a refresh that expires in the same cycle.
        if (xon_cause) begin
          state_d = ST_XON_REQ;
          req_d   = 1'b1;
          val_d   = '0;
          addr_d  = PAUSE_DA;
        end else if (refresh_tc) begin
          state_d = ST_XOFF_REQ;
          req_d   = 1'b1;
          val_d   = PAUSE_QUANTA;
          addr_d  = PAUSE_DA;
        end else begin
          refresh_d = refresh_q - REFRESH_W'(1);
        end
      end

      ST_XON_REQ: begin
        if (ack_valid) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          val_d    = '0;
          addr_d   = '0;
          paused_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        req_d    = 1'b0;
        val_d    = '0;
        addr_d   = '0;
        paused_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      val_q      <= '0;
      addr_q     <= '0;
      paused_q   <= 1'b0;
      xoff_cnt_q <= '0;
      refresh_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      val_q      <= val_d;
      addr_q     <= addr_d;
      paused_q   <= paused_d;
      xoff_cnt_q <= xoff_cnt_d;
      refresh_q  <= refresh_d;
    end
  end

  assign pif.tx_pause_req           = req_q;
  assign pif.tx_pause_val           = val_q;
  assign pif.tx_pause_source_addr_r = addr_q;
  assign pif.paused                 = paused_q;
  assign pif.xoff_count             = xoff_cnt_q;

endmodule

// File: tb/tb_pause_frame_scheduler.sv
// Directed bench for pause_frame_scheduler: timestamp-based reference model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pause_frame_scheduler;
  localparam int          FILL_W  = 12;
  localparam int          XOFF_T  = 3072;
  localparam int          XON_T   = 1024;
  localparam logic [15:0] QUANTA  = 16'h5A0F;
  localparam int          REFRESH = 100;
  localparam logic [47:0] DA      = 48'h0180C2000001;

  logic tx_clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  bit   preset_sat = 0;

  pause_frame_scheduler_if #(.FILL_W(FILL_W)) pif ();

  pause_frame_scheduler #(
    .FILL_W(FILL_W), .XOFF_THRESH(XOFF_T), .XON_THRESH(XON_T), .PAUSE_QUANTA(QUANTA),
    .REFRESH_W(20), .REFRESH_CYCLES(REFRESH), .PAUSE_DA(DA)
  ) dut (
    .tx_clk(tx_clk),
    .rst(rst),
    .pif(pif.master)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  // Reference model: a pending request plus a paused flag and the cycle at which a refresh falls due.
  longint      cyc = 0;
  longint      refresh_at = 0;
  bit          m_req = 0;
  bit          m_is_xon = 0;
  logic [15:0] m_val = '0;
  logic [47:0] m_addr = '0;
  bit          m_paused = 0;
  int          m_count = 0;

  always @(posedge tx_clk) begin
    cyc++;
    if (rst) begin
      m_req = 0; m_is_xon = 0; m_val = '0; m_addr = '0; m_paused = 0; m_count = 0;
    end else begin
      if (preset_sat) m_count = 65535;
      if (m_req) begin
        if (pif.tx_pause_ack) begin
          m_req = 0; m_val = '0; m_addr = '0;
          if (m_is_xon) m_paused = 0;
          else begin
            m_paused = 1;
            m_count = (m_count < 65535) ? m_count + 1 : 65535;
            refresh_at = cyc + REFRESH;
          end
        end
      end else if (m_paused) begin
        if (!pif.pause_enable || int'(pif.fifo_level) <= XON_T) begin
          m_req = 1; m_is_xon = 1; m_val = '0; m_addr = DA;
        end else if (cyc >= refresh_at) begin
          m_req = 1; m_is_xon = 0; m_val = QUANTA; m_addr = DA;
        end
      end else if (pif.pause_enable && int'(pif.fifo_level) >= XOFF_T) begin
        m_req = 1; m_is_xon = 0; m_val = QUANTA; m_addr = DA;
      end
    end
  end

  always @(negedge tx_clk) begin
    if (chk_en) begin
      checks++;
      if (pif.tx_pause_req !== m_req || pif.tx_pause_val !== m_val ||
          pif.tx_pause_source_addr_r !== m_addr || pif.paused !== m_paused ||
          pif.xoff_count !== 16'(m_count)) begin
        errors++;
        $display("FAIL model_cmp t=%0t got req=%b val=%h addr=%h paused=%b cnt=%h want req=%b val=%h addr=%h paused=%b cnt=%h",
                 $time, pif.tx_pause_req, pif.tx_pause_val, pif.tx_pause_source_addr_r, pif.paused,
                 pif.xoff_count, m_req, m_val, m_addr, m_paused, 16'(m_count));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tx_clk);
    #2;
  endtask

  task automatic ack_pulse();
    pif.tx_pause_ack = 1'b1;
    step();
    pif.tx_pause_ack = 1'b0;
  endtask

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (!pif.tx_pause_req && n < limit) begin
      step();
      n++;
    end
    if (!pif.tx_pause_req) begin
      errors++;
      $display("FAIL wait_req_timeout got=0 want=1 after %0d cycles", n);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    pif.fifo_level   = '0;
    pif.pause_enable = 1'b1;
    pif.tx_pause_ack = 1'b0;
    repeat (3) step();
    chk_en = 1;
    chk("reset_outputs", {pif.tx_pause_req, pif.tx_pause_val, pif.tx_pause_source_addr_r != 0,
        pif.paused, pif.xoff_count}, 64'd0);
    rst = 1'b0;
    step();

    // First XOFF, held without ack, then acknowledged
    pif.fifo_level = 12'd3072;
    step();
    chk("xoff_req", pif.tx_pause_req, 1);
    chk("xoff_val", pif.tx_pause_val, 64'h5A0F);
    chk("xoff_addr", pif.tx_pause_source_addr_r, 64'h0180C2000001);
    repeat (5) step();
    chk("xoff_held", {pif.tx_pause_req, pif.tx_pause_val}, {47'd0, 1'b1, 16'h5A0F});
    ack_pulse();
    chk("xoff_ack_req", pif.tx_pause_req, 0);
    chk("xoff_ack_paused", pif.paused, 1);
    chk("xoff_ack_count", pif.xoff_count, 1);

    // Hysteresis band, then XON at the lower threshold
    pif.fifo_level = 12'd2000;
    repeat (10) step();
    chk("hyst_no_req", pif.tx_pause_req, 0);
    pif.fifo_level = 12'd1024;
    step();
    chk("xon_req", {pif.tx_pause_req, pif.tx_pause_val}, {47'd0, 1'b1, 16'h0000});
    ack_pulse();
    chk("xon_ack_paused", pif.paused, 0);

    // Refresh interval while congested
    pif.fifo_level = 12'd4000;
    step();
    ack_pulse();
    chk("count_2", pif.xoff_count, 2);
    wait_req(200, n);
    chk("refresh_latency", 64'(n), 64'd100);
    chk("refresh_val", pif.tx_pause_val, 64'h5A0F);
    chk("refresh_paused", pif.paused, 1);
    ack_pulse();
    chk("count_3", pif.xoff_count, 3);

    // XON and refresh expiry in the same cycle: XON wins
    repeat (99) step();
    pif.fifo_level = 12'd1000;
    step();
    chk("xon_priority", {pif.tx_pause_req, pif.tx_pause_val, pif.xoff_count}, {31'd0, 1'b1, 16'h0000, 16'd3});
    ack_pulse();

    // pause_enable low while paused, then in IDLE with a full FIFO
    pif.fifo_level = 12'd4000;
    step();
    ack_pulse();
    pif.pause_enable = 1'b0;
    step();
    chk("disable_xon", {pif.tx_pause_req, pif.tx_pause_val}, {47'd0, 1'b1, 16'h0000});
    ack_pulse();
    pif.fifo_level = 12'd4095;
    repeat (10) step();
    chk("disabled_idle", {pif.tx_pause_req, pif.paused}, 64'd0);

    // Reset while a request is pending, then a spurious ack
    pif.pause_enable = 1'b1;
    step();
    chk("pre_reset_req", pif.tx_pause_req, 1);
    rst = 1'b1;
    pif.fifo_level = '0;
    step();
    chk("mid_reset_clear", {pif.tx_pause_req, pif.tx_pause_val, pif.tx_pause_source_addr_r != 0,
        pif.paused, pif.xoff_count}, 64'd0);
    rst = 1'b0;
    step();
    ack_pulse();
    step();
    chk("spurious_ack", {pif.tx_pause_req, pif.paused, pif.xoff_count}, 64'd0);

    // Saturation of the XOFF counter
    pif.fifo_level = 12'd4000;
    step();
    ack_pulse();
    @(negedge tx_clk);
    #1;
    force dut.xoff_cnt_q = 16'hFFFF;
    preset_sat = 1;
    #1;
    release dut.xoff_cnt_q;
    step();
    preset_sat = 0;
    wait_req(200, n);
    ack_pulse();
    chk("count_saturated", pif.xoff_count, 64'hFFFF);
    chk("sat_paused", pif.paused, 1);

    pif.fifo_level = '0;
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=timeout want=finish");
    $fatal(1, "timeout");
  end
endmodule
